// File: rtl/clk_div_multi_pkg.sv
// Shared constants, config record type and config validation rule for the
// multi-channel clock divider.
package clk_div_multi_pkg;

   localparam int CDM_N_CH    = 4;
   localparam int CDM_W       = 16;
   localparam int CDM_DEF_DIV = 2;

   typedef struct packed {
      logic [CDM_W-1:0] div;
      logic [CDM_W-1:0] high;
   } ch_cfg_t;

   // Accept (1) or reject (0) a divisor/high-time pair.
   // div==1 is only meaningful with high==1 (constant-high output).
   function automatic logic cfg_valid_chk(input logic [31:0] div, input logic [31:0] high);
      logic ok;
      ok = 1'b1;
      if (div == 32'd0 || high == 32'd0)
         ok = 1'b0;
      else if (div >= 32'd2 && high >= div)
         ok = 1'b0;
      else if (div == 32'd1 && high != 32'd1)
         ok = 1'b0;
      return ok;
   endfunction

endpackage

// File: rtl/clk_div_multi_ch.sv
// One divider channel: period counter, shadow/active settings, pending flag
// and registered clk_out/tick. Settings move from shadow to active only at a
// period boundary (or while the channel is stopped), so no runt pulses occur.
// Optional macro CLK_DIV_MULTI_SYNC_EN adds the sync input.
module clk_div_multi_ch
   import clk_div_multi_pkg::*;
#(
   parameter int W       = CDM_W,
   parameter int DEF_DIV = CDM_DEF_DIV
) (
   input  logic         clk,
   input  logic         rst,
`ifdef CLK_DIV_MULTI_SYNC_EN
   input  logic         sync,
`endif
   input  logic         en,
   input  logic         wr,
   input  logic [W-1:0] wr_div,
   input  logic [W-1:0] wr_high,
   output logic         pend,
   output logic         clk_out,
   output logic         tick
);

   logic [W-1:0] cnt;
   logic [W-1:0] div_act;
   logic [W-1:0] high_act;
   logic [W-1:0] div_sh;
   logic [W-1:0] high_sh;
   logic         boundary;
   logic         apply;
   logic         restart;

   assign boundary = en & (cnt == div_act - W'(1));

`ifdef CLK_DIV_MULTI_SYNC_EN
   assign apply   = pend & (~en | boundary | sync);
   assign restart = boundary | apply | sync;
`else
   assign apply   = pend & (~en | boundary);
   assign restart = boundary | apply;
`endif

   // Channel state: shadow capture, boundary apply, counting and outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt      <= '0;
         div_act  <= W'(DEF_DIV);
         high_act <= W'(DEF_DIV / 2);
         div_sh   <= W'(DEF_DIV);
         high_sh  <= W'(DEF_DIV / 2);
         pend     <= 1'b0;
         clk_out  <= 1'b0;
         tick     <= 1'b0;
      end else begin
         if (wr) begin
            div_sh  <= wr_div;
            high_sh <= wr_high;
         end

         // A write only happens while pend is clear, so it never collides
         // with an apply; a write on a boundary waits for the next one.
         if (wr)
            pend <= 1'b1;
         else if (apply)
            pend <= 1'b0;

         if (apply) begin
            div_act  <= div_sh;
            high_act <= high_sh;
         end

         if (en) begin
            clk_out <= (cnt < high_act);
            tick    <= boundary;
            cnt     <= restart ? '0 : cnt + W'(1);
         end else begin
            clk_out <= 1'b0;
            tick    <= 1'b0;
            cnt     <= '0;
         end
      end
   end

endmodule

// File: rtl/clk_div_multi.sv
// N-channel programmable-duty clock divider top: config decode, valid/ready
// handshake and reject pulse; channels are independent instances.
// Optional macro CLK_DIV_MULTI_SYNC_EN adds a sync input that restarts all
// enabled channels and applies every pending config in the same cycle.
module clk_div_multi
   import clk_div_multi_pkg::*;
#(
   parameter int N_CH    = CDM_N_CH,
   parameter int W       = CDM_W,
   parameter int DEF_DIV = CDM_DEF_DIV,
   localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic            clk,
   input  logic            rst,
`ifdef CLK_DIV_MULTI_SYNC_EN
   input  logic            sync,
`endif
   input  logic [N_CH-1:0] en,
   input  logic            cfg_valid,
   output logic            cfg_ready,
   input  logic [CH_W-1:0] cfg_ch,
   input  logic [W-1:0]    cfg_div,
   input  logic [W-1:0]    cfg_high,
   output logic            cfg_err,
   output logic [N_CH-1:0] pend,
   output logic [N_CH-1:0] clk_out,
   output logic [N_CH-1:0] tick
);

   localparam int CH_SPAN = 1 << CH_W;

   logic [CH_SPAN-1:0] pend_pad;
   logic               xfer;
   logic               ch_ok;
   logic               bad;
   logic [N_CH-1:0]    wr;

   // Out-of-range channel numbers see a free slot so the request transfers
   // and is then rejected, rather than stalling the requester forever.
   assign pend_pad  = CH_SPAN'(pend);
   assign cfg_ready = ~rst & ~pend_pad[cfg_ch];
   assign xfer      = cfg_valid & cfg_ready;
   assign ch_ok     = (32'(cfg_ch) < 32'(N_CH));
   assign bad       = ~ch_ok | ~cfg_valid_chk(32'(cfg_div), 32'(cfg_high));

   // Reject pulse, one cycle after a rejected transfer.
   always_ff @(posedge clk) begin
      if (rst)
         cfg_err <= 1'b0;
      else
         cfg_err <= xfer & bad;
   end

   generate
      for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
         assign wr[gi] = xfer & ~bad & (cfg_ch == CH_W'(gi));

         clk_div_multi_ch #(
            .W       (W),
            .DEF_DIV (DEF_DIV)
         ) u_ch (
            .clk     (clk),
            .rst     (rst),
`ifdef CLK_DIV_MULTI_SYNC_EN
            .sync    (sync),
`endif
            .en      (en[gi]),
            .wr      (wr[gi]),
            .wr_div  (cfg_div),
            .wr_high (cfg_high),
            .pend    (pend[gi]),
            .clk_out (clk_out[gi]),
            .tick    (tick[gi])
         );
      end
   endgenerate

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed self-checking bench for clk_div_multi (4 channels) plus a 3-channel
// instance used for the out-of-range channel number case.
`timescale 1ns/1ps
module tb_clk_div_multi;
   import clk_div_multi_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  en = 4'b0000;
   logic        cfg_valid = 1'b0;
   logic        cfg_ready;
   logic [1:0]  cfg_ch = 2'd0;
   logic [15:0] cfg_div = 16'd0;
   logic [15:0] cfg_high = 16'd0;
   logic        cfg_err;
   logic [3:0]  pend;
   logic [3:0]  clk_out;
   logic [3:0]  tick;

   logic [2:0]  en2 = 3'b000;
   logic        cfg2_valid = 1'b0;
   logic        cfg2_ready;
   logic [1:0]  cfg2_ch = 2'd0;
   logic [15:0] cfg2_div = 16'd0;
   logic [15:0] cfg2_high = 16'd0;
   logic        cfg2_err;
   logic [2:0]  pend2;
   logic [2:0]  clk_out2;
   logic [2:0]  tick2;

`ifdef CLK_DIV_MULTI_SYNC_EN
   logic        sync = 1'b0;
`endif

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   clk_div_multi #(.N_CH(4), .W(16), .DEF_DIV(2)) dut (
      .clk       (clk),
      .rst       (rst),
`ifdef CLK_DIV_MULTI_SYNC_EN
      .sync      (sync),
`endif
      .en        (en),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_ch    (cfg_ch),
      .cfg_div   (cfg_div),
      .cfg_high  (cfg_high),
      .cfg_err   (cfg_err),
      .pend      (pend),
      .clk_out   (clk_out),
      .tick      (tick)
   );

   clk_div_multi #(.N_CH(3), .W(16), .DEF_DIV(2)) dut3 (
      .clk       (clk),
      .rst       (rst),
`ifdef CLK_DIV_MULTI_SYNC_EN
      .sync      (sync),
`endif
      .en        (en2),
      .cfg_valid (cfg2_valid),
      .cfg_ready (cfg2_ready),
      .cfg_ch    (cfg2_ch),
      .cfg_div   (cfg2_div),
      .cfg_high  (cfg2_high),
      .cfg_err   (cfg2_err),
      .pend      (pend2),
      .clk_out   (clk_out2),
      .tick      (tick2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
      $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic req(input logic [1:0] ch, input ch_cfg_t c);
      cfg_valid = 1'b1;
      cfg_ch    = ch;
      cfg_div   = c.div;
      cfg_high  = c.high;
   endtask

   initial begin
      logic [9:0] p1_clk;
      logic [9:0] p1_tick;
      logic [6:0] p4_clk;
      logic [6:0] p4_tick;
      logic [6:0] p4_pend;
      logic [5:0] p5_clk;
      logic [5:0] p5_tick;
      logic [5:0] p5_pend;
      logic [4:0] p7_clk;
      logic [4:0] p7_tick;

      p1_clk  = 10'b1100011000;
      p1_tick = 10'b0000100001;
      p4_clk  = 7'b0011001;
      p4_tick = 7'b0100010;
      p4_pend = 7'b1000000;
      p5_clk  = 6'b101001;
      p5_tick = 6'b010010;
      p5_pend = 6'b100000;
      p7_clk  = 5'b11101;
      p7_tick = 5'b00010;

      // validation rule
      chk("fn_5_2", 32'(cfg_valid_chk(32'd5, 32'd2)), 32'd1);
      chk("fn_7_7", 32'(cfg_valid_chk(32'd7, 32'd7)), 32'd0);
      chk("fn_1_1", 32'(cfg_valid_chk(32'd1, 32'd1)), 32'd1);

      // reset
      repeat (3) step();
      chk("rst_clk", 32'(clk_out), 32'h0);
      chk("rst_tick", 32'(tick), 32'h0);
      chk("rst_pend", 32'(pend), 32'h0);
      chk("rst_err", 32'(cfg_err), 32'h0);
      chk("rst_ready", 32'(cfg_ready), 32'h0);

      // defaults: period 2, high 1, first high one cycle after en
      rst = 1'b0;
      en  = 4'b1111;
      for (int k = 1; k <= 4; k++) begin
         step();
         chk("def_clk", 32'(clk_out), (k % 2 == 1) ? 32'hF : 32'h0);
         chk("def_tick", 32'(tick), (k % 2 == 1) ? 32'h0 : 32'hF);
      end

      // ch1 -> div 5 high 2 while running
      req(2'd1, '{div: 16'd5, high: 16'd2});
      #1;
      chk("p2_ready0", 32'(cfg_ready), 32'h1);
      step();
      chk("p2_pend", 32'(pend), 32'h2);
      chk("p2_ready1", 32'(cfg_ready), 32'h0);
      cfg_valid = 1'b0;
      step();
      chk("p2_pend_clr", 32'(pend), 32'h0);
      chk("p2_bnd_clk", 32'(clk_out[1]), 32'h0);
      chk("p2_bnd_tick", 32'(tick[1]), 32'h1);
      for (int i = 0; i < 10; i++) begin
         step();
         chk("p2_clk1", 32'(clk_out[1]), 32'(p1_clk[9-i]));
         chk("p2_tick1", 32'(tick[1]), 32'(p1_tick[9-i]));
         chk("p2_clk0", 32'(clk_out[0]), (i % 2 == 0) ? 32'h1 : 32'h0);
      end

      // rejected requests
      req(2'd2, '{div: 16'd7, high: 16'd7});
      cfg2_valid = 1'b1;
      cfg2_ch    = 2'd3;
      cfg2_div   = 16'd4;
      cfg2_high  = 16'd2;
      #1;
      chk("p3_ready", 32'(cfg_ready), 32'h1);
      chk("p3_ready2", 32'(cfg2_ready), 32'h1);
      step();
      chk("p3_err_a", 32'(cfg_err), 32'h1);
      chk("p3_err_ch", 32'(cfg2_err), 32'h1);
      chk("p3_pend_a", 32'(pend), 32'h0);
      chk("p3_pend2", 32'(pend2), 32'h0);
      chk("p3_clk1_a", 32'(clk_out[1]), 32'h1);
      chk("p3_clk2_a", 32'(clk_out[2]), 32'h1);
      cfg2_valid = 1'b0;
      req(2'd0, '{div: 16'd0, high: 16'd1});
      step();
      chk("p3_err_b", 32'(cfg_err), 32'h1);
      chk("p3_err2_clr", 32'(cfg2_err), 32'h0);
      chk("p3_pend_b", 32'(pend), 32'h0);
      chk("p3_clk1_b", 32'(clk_out[1]), 32'h1);
      chk("p3_clk2_b", 32'(clk_out[2]), 32'h0);
      req(2'd1, '{div: 16'd1, high: 16'd2});
      step();
      chk("p3_err_c", 32'(cfg_err), 32'h1);
      chk("p3_pend_c", 32'(pend), 32'h0);
      chk("p3_clk1_c", 32'(clk_out[1]), 32'h0);
      cfg_valid = 1'b0;
      step();
      chk("p3_err_clr", 32'(cfg_err), 32'h0);
      chk("p3_clk1_d", 32'(clk_out[1]), 32'h0);

      // second request to ch1 while pending
      step();
      req(2'd1, '{div: 16'd3, high: 16'd1});
      step();
      chk("p4_pend_a", 32'(pend), 32'h2);
      req(2'd1, '{div: 16'd4, high: 16'd2});
      #1;
      chk("p4_block", 32'(cfg_ready), 32'h0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("p4_hold_pend", 32'(pend[1]), 32'h1);
         chk("p4_hold_rdy", 32'(cfg_ready), 32'h0);
      end
      step();
      chk("p4_apply", 32'(pend), 32'h0);
      chk("p4_ready", 32'(cfg_ready), 32'h1);
      chk("p4_old_clk", 32'(clk_out[1]), 32'h0);
      chk("p4_old_tick", 32'(tick[1]), 32'h1);
      step();
      chk("p4_pend_b", 32'(pend), 32'h2);
      chk("p4_rdy_b", 32'(cfg_ready), 32'h0);
      chk("p4_clk_a", 32'(clk_out[1]), 32'h1);
      chk("p4_tick_a", 32'(tick[1]), 32'h0);
      cfg_valid = 1'b0;
      for (int i = 0; i < 7; i++) begin
         step();
         chk("p4_clk1", 32'(clk_out[1]), 32'(p4_clk[6-i]));
         chk("p4_tick1", 32'(tick[1]), 32'(p4_tick[6-i]));
         chk("p4_pend1", 32'(pend[1]), 32'(p4_pend[6-i]));
      end

      // ch3 transfer on its own boundary: one more old period
      step();
      req(2'd3, '{div: 16'd3, high: 16'd1});
      #1;
      chk("p5_ready", 32'(cfg_ready), 32'h1);
      step();
      chk("p5_pend", 32'(pend), 32'h8);
      chk("p5_clk3", 32'(clk_out[3]), 32'h0);
      chk("p5_tick3", 32'(tick[3]), 32'h1);
      cfg_valid = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step();
         chk("p5_clk3", 32'(clk_out[3]), 32'(p5_clk[5-i]));
         chk("p5_tick3", 32'(tick[3]), 32'(p5_tick[5-i]));
         chk("p5_pend3", 32'(pend[3]), 32'(p5_pend[5-i]));
      end

      // reset with ch0 pending
      req(2'd0, '{div: 16'd3, high: 16'd1});
      step();
      chk("p6_pend", 32'(pend), 32'h1);
      cfg_valid = 1'b0;
      rst = 1'b1;
      step();
      chk("p6_clk", 32'(clk_out), 32'h0);
      chk("p6_tick", 32'(tick), 32'h0);
      chk("p6_pend0", 32'(pend), 32'h0);
      chk("p6_err", 32'(cfg_err), 32'h0);
      chk("p6_ready", 32'(cfg_ready), 32'h0);
      rst = 1'b0;
      #1;
      chk("p6_ready1", 32'(cfg_ready), 32'h1);
      for (int i = 0; i < 4; i++) begin
         step();
         chk("p6_def_clk", 32'(clk_out), (i % 2 == 0) ? 32'hF : 32'h0);
         chk("p6_def_tick", 32'(tick), (i % 2 == 0) ? 32'h0 : 32'hF);
      end

      // ch2 disabled: outputs low, config applies immediately while stopped
      en = 4'b1011;
      step();
      chk("p7_clk2_off", 32'(clk_out[2]), 32'h0);
      chk("p7_tick2_off", 32'(tick[2]), 32'h0);
      chk("p7_clk0_on", 32'(clk_out[0]), 32'h1);
      req(2'd2, '{div: 16'd4, high: 16'd3});
      step();
      chk("p7_pend", 32'(pend), 32'h4);
      chk("p7_clk2_off2", 32'(clk_out[2]), 32'h0);
      cfg_valid = 1'b0;
      step();
      chk("p7_apply", 32'(pend), 32'h0);
      en = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("p7_clk2", 32'(clk_out[2]), 32'(p7_clk[4-i]));
         chk("p7_tick2", 32'(tick[2]), 32'(p7_tick[4-i]));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
